div_16_bit: RTL and testbench



---
 rtl/div16_pkg.sv | 22 ++
 rtl/div16_step.sv | 28 ++
 rtl/div_16_bit.sv | 114 +++++++++++
 tb/tb_div_16_bit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/div16_pkg.sv
// ============================================================================
//  div16_pkg : shared widths, step count and FSM state type for div_16_bit
//  Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package div16_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int REM_W      = 17;
  localparam int STEPS      = 16;
  localparam int CNT_W      = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : div16_pkg

`default_nettype wire

// File: rtl/div16_step.sv
// ============================================================================
//  div16_step : one combinational radix-2 restoring division step
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module div16_step
  import div16_pkg::*;
(
  input  logic [REM_W-1:0]     rem_in,
  input  logic                 dividend_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [REM_W-1:0]     rem_out,
  output logic                 q_bit
);

  // One extra top bit keeps the compare exact even when divisor is zero and
  // the partial remainder keeps growing.
  logic [REM_W:0] shifted;

  assign shifted = {rem_in, dividend_bit};
  assign q_bit   = (shifted >= {{(REM_W + 1 - DIVISOR_W){1'b0}}, divisor});
  assign rem_out = q_bit ? (shifted[REM_W-1:0] - {{(REM_W - DIVISOR_W){1'b0}}, divisor})
                         : shifted[REM_W-1:0];

endmodule : div16_step

`default_nettype wire

// File: rtl/div_16_bit.sv
// ============================================================================
//  div_16_bit : iterative 16/8 unsigned restoring divider, 16-cycle latency
//               Optional DIV16_DBZ_EN adds a registered divide-by-zero flag.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_16_bit
  import div16_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] A,
  input  logic [DIVISOR_W-1:0]  B,
  output logic [DIVIDEND_W-1:0] result,
  output logic [DIVIDEND_W-1:0] odd,
  output logic                  busy,
  output logic                  done
`ifdef DIV16_DBZ_EN
  ,
  output logic                  dbz
`endif
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [REM_W-1:0]        rem_q;
  logic [DIVIDEND_W-1:0]   dvd_q;     // dividend bits shift out, quotient bits shift in
  logic [DIVISOR_W-1:0]    dvs_q;
  logic [DIVIDEND_W-1:0]   result_q;
  logic [DIVIDEND_W-1:0]   odd_q;
  logic                    busy_q;
  logic                    done_q;

  logic [REM_W-1:0]        rem_d;
  logic                    qbit_d;
  logic [DIVIDEND_W-1:0]   quo_d;

  div16_step u_step (
    .rem_in       (rem_q),
    .dividend_bit (dvd_q[DIVIDEND_W-1]),
    .divisor      (dvs_q),
    .rem_out      (rem_d),
    .q_bit        (qbit_d)
  );

  assign quo_d = {dvd_q[DIVIDEND_W-2:0], qbit_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      odd_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q   <= A;
            dvs_q   <= B;
            cnt_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          dvd_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            result_q <= quo_d;
            odd_q    <= rem_d[DIVIDEND_W-1:0];
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DIV16_DBZ_EN
  logic dbz_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dbz_q <= 1'b0;
    end else if (state_q == RUN && cnt_q == LAST_STEP) begin
      dbz_q <= (dvs_q == '0);
    end
  end

  assign dbz = dbz_q;
`endif

  assign result = result_q;
  assign odd    = odd_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule : div_16_bit

`default_nettype wire

// File: tb/tb_div_16_bit.sv
// ============================================================================
//  tb_div_16_bit : randomized self-checking bench for div_16_bit
//  Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_16_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [7:0]  B;
  logic [15:0] result;
  logic [15:0] odd;
  logic        busy;
  logic        done;
`ifdef DIV16_DBZ_EN
  logic        dbz;
`endif

  int checks   = 0;
  int failures = 0;

  div_16_bit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .result (result),
    .odd    (odd),
    .busy   (busy),
    .done   (done)
`ifdef DIV16_DBZ_EN
    ,
    .dbz    (dbz)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference: plain arithmetic, divide-by-zero gives all-ones quotient and A back.
  function automatic void ref_div(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [15:0] r);
    if (b == 8'd0) begin
      q = 16'hFFFF;
      r = a;
    end else begin
      q = a / {8'd0, b};
      r = a % {8'd0, b};
    end
  endfunction

  // Drive a one-cycle start; returns just after the sampling edge N.
  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Counts edges until done is seen (bounded); 0 means it never came.
  task automatic wait_done(input int limit, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      cyc = 0;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [7:0] b);
    logic [15:0] q, r;
    ref_div(a, b, q, r);
    check({tag, "_q"}, {16'd0, result}, {16'd0, q});
    check({tag, "_r"}, {16'd0, odd}, {16'd0, r});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
`ifdef DIV16_DBZ_EN
    check({tag, "_dbz"}, {31'd0, dbz}, {31'd0, (b == 8'd0)});
`endif
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [7:0] b);
    int cyc;
    launch(a, b);
    wait_done(40, cyc);
    check({tag, "_lat"}, cyc, 32'd16);
    check_result(tag, a, b);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int          cyc;
    int          dones;
    logic [15:0] prev_res;
    logic [15:0] cur_a;
    logic [7:0]  cur_b;

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_odd",    {16'd0, odd},    32'd0);
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_done",   {31'd0, done},   32'd0);
`ifdef DIV16_DBZ_EN
    check("rst_dbz",    {31'd0, dbz},    32'd0);
`endif

    directed("d1000_7",   16'd1000,  8'd7);
    directed("d65535_1",  16'd65535, 8'd1);
    directed("d5_200",    16'd5,     8'd200);
    directed("d65535_255",16'd65535, 8'd255);
    directed("d1234_0",   16'd1234,  8'd0);
    directed("d0_9",      16'd0,     8'd9);

    // A second start mid-operation must be ignored, and operands stay latched.
    launch(16'd1000, 8'd7);
    prev_res = result;
    repeat (4) @(posedge clk);
    @(negedge clk);
    A     = 16'd9;
    B     = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_stable", {16'd0, result}, {16'd0, prev_res});
    wait_done(40, cyc);
    check("ign_lat", cyc, 32'd11);
    check_result("ign", 16'd1000, 8'd7);
    dones = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("ign_no_second", dones, 32'd0);

    // Reset at cycle 8 aborts the operation with no done pulse.
    launch(16'd1000, 8'd7);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_result", {16'd0, result}, 32'd0);
    check("abort_odd",    {16'd0, odd},    32'd0);
    check("abort_busy",   {31'd0, busy},   32'd0);
    dones = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("abort_no_done", dones, 32'd0);
    directed("after_abort", 16'd4321, 8'd13);

    // Back-to-back random operations with start held high.
    @(negedge clk);
    cur_a = 16'($urandom_range(0, 65535));
    cur_b = 8'($urandom_range(1, 255));
    A     = cur_a;
    B     = cur_b;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 100; i++) begin
      wait_done(40, cyc);
      check("rnd_lat", cyc, (i == 0) ? 32'd16 : 32'd17);
      check_result("rnd", cur_a, cur_b);
      cur_a = 16'($urandom_range(0, 65535));
      cur_b = 8'($urandom_range(1, 255));
      A     = cur_a;
      B     = cur_b;
      if (i == 99) start = 1'b0;
    end
    start = 1'b0;
    repeat (20) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_div_16_bit

`default_nettype wire
